// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for a classic five-stage pipeline. It produces the
// stall/flush controls consumed by the PC, IF/ID and ID/EX pipeline registers:
//   * Load-use: when the instruction in ID reads a register that a load in EX
//     is about to write, the PC and IF/ID are held and ID/EX receives bubbles
//     for LOAD_STALL_CYCLES consecutive cycles.
//   * Taken branch / jump resolved in EX: the wrong-path instructions in IF/ID
//     and ID/EX are squashed while the PC loads the target. A flush overrides
//     a fresh hazard and aborts any stall still in progress.
// Two saturating counters report load-use bubble cycles and flush events.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (legal 1..7)
//   CNT_W              width of each statistics counter
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   id_inst          instruction currently held in IF/ID
//   ex_MemRead       instruction in EX is a load
//   ex_rt            destination register of the EX instruction
//   ex_branch_taken  EX resolved a taken branch this cycle
//   ex_jump          EX instruction is a jump
//   pc_write         PC update enable
//   ifid_write       IF/ID load enable
//   ifid_flush       IF/ID clear-to-NOP
//   idex_stall       ID/EX loads a bubble (all controls zero) at next edge
//   stall_cycles     load-use bubble cycles since reset (saturating)
//   flush_count      flush events since reset (saturating)
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_inst,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // Remaining-bubble count loaded when a hazard is first seen; the detecting
  // cycle itself is the first bubble, so LSTALL covers the remainder.
  localparam logic [2:0]       REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Opcodes whose rt field is a source operand: R-type, beq, bne, sw.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Counter indices inside the statistics array.
  localparam int CNT_STALL = 0;
  localparam int CNT_FLUSH = 1;
  localparam int NUM_CNT   = 2;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       unused_inst_bits;

  assign id_opcode = id_inst[31:26];
  assign id_rs     = id_inst[25:21];
  assign id_rt     = id_inst[20:16];

  // The low half (rd/shamt/funct/immediate) plays no part in hazard detection.
  assign unused_inst_bits = ^id_inst[15:0];

  always_comb begin
    id_uses_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: id_uses_rt = 1'b1;
      default:                         id_uses_rt = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard / flush detection
  // ---------------------------------------------------------------------------
  logic hazard;
  logic flush;

  // $0 is hard-wired zero, so a load targeting it never creates a dependence.
  assign hazard = ex_MemRead && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign flush  = ex_branch_taken || ex_jump;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [2:0]         rem_q, rem_d;
  logic [NUM_CNT-1:0] cnt_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    // Normal flow by default.
    state_d    = state_q;
    rem_d      = rem_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    cnt_inc    = '0;

    if (!reset) begin
      // Outputs forced to normal flow while reset is held, whatever the
      // inputs say; the registers are already being cleared asynchronously.
      state_d = RUN;
      rem_d   = 3'd0;
    end else if (flush) begin
      // Squash both wrong-path slots while the PC takes the target. Any stall
      // in progress is abandoned: the dependent instruction is being killed.
      ifid_flush         = 1'b1;
      idex_stall         = 1'b1;
      cnt_inc[CNT_FLUSH] = 1'b1;
      state_d            = RUN;
      rem_d              = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_write           = 1'b0;
            ifid_write         = 1'b0;
            idex_stall         = 1'b1;
            cnt_inc[CNT_STALL] = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LSTALL;
              rem_d   = REM_INIT;
            end
          end
        end

        LSTALL: begin
          // The load has moved on, so the hazard inputs are no longer looked
          // at; the remaining bubbles are inserted unconditionally.
          pc_write           = 1'b0;
          ifid_write         = 1'b0;
          idex_stall         = 1'b1;
          cnt_inc[CNT_STALL] = 1'b1;
          rem_d              = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d = RUN;
          end
        end

        default: begin
          state_d = RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_inc[gi] && (cnt_q[gi] != CNT_MAX)) begin
          cnt_d[gi] = cnt_q[gi] + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign stall_cycles = cnt_q[CNT_STALL];
  assign flush_count  = cnt_q[CNT_FLUSH];

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Three hazard_unit instances share one stimulus stream:
//   u0: LOAD_STALL_CYCLES=1, CNT_W=16
//   u1: LOAD_STALL_CYCLES=3, CNT_W=16
//   u2: LOAD_STALL_CYCLES=1, CNT_W=4   (counter saturation)
// Each is compared every cycle against a reference model that tracks
// "bubbles still owed" as a plain integer and counters as integers clamped to
// their maximum. Directed steps follow the test plan, then random traffic.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic [31:0] id_inst;
  logic        ex_MemRead;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        ex_jump;

  logic        pw0, iw0, fl0, st0;
  logic        pw1, iw1, fl1, st1;
  logic        pw2, iw2, fl2, st2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .id_inst(id_inst), .ex_MemRead(ex_MemRead),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(pw0), .ifid_write(iw0), .ifid_flush(fl0), .idex_stall(st0),
    .stall_cycles(sc0), .flush_count(fc0));

  hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .id_inst(id_inst), .ex_MemRead(ex_MemRead),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1), .idex_stall(st1),
    .stall_cycles(sc1), .flush_count(fc1));

  hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .id_inst(id_inst), .ex_MemRead(ex_MemRead),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2), .idex_stall(st2),
    .stall_cycles(sc2), .flush_count(fc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed values gathered per instance, ctrl = {pc_write, ifid_write, ifid_flush, idex_stall}.
  logic [3:0]  ctrl_obs [NI];
  logic [15:0] sc_obs   [NI];
  logic [15:0] fc_obs   [NI];

  assign ctrl_obs[0] = {pw0, iw0, fl0, st0};
  assign ctrl_obs[1] = {pw1, iw1, fl1, st1};
  assign ctrl_obs[2] = {pw2, iw2, fl2, st2};
  assign sc_obs[0]   = sc0;
  assign sc_obs[1]   = sc1;
  assign sc_obs[2]   = {12'd0, sc2};
  assign fc_obs[0]   = fc0;
  assign fc_obs[1]   = fc1;
  assign fc_obs[2]   = {12'd0, fc2};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int lsc_m  [NI] = '{1, 3, 1};
  int max_m  [NI] = '{65535, 65535, 15};
  int owed_m [NI];   // bubbles still owed beyond the current cycle
  int sc_m   [NI];
  int fc_m   [NI];

  int checks   = 0;
  int failures = 0;

  function automatic bit is_hazard(logic [31:0] inst, logic mr, logic [4:0] rt_ex);
    logic [5:0] op;
    bit         reads_rt;
    op       = inst[31:26];
    reads_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
    return mr && (rt_ex != 5'd0) &&
           ((rt_ex == inst[25:21]) || (reads_rt && (rt_ex == inst[20:16])));
  endfunction

  function automatic logic [3:0] model_ctrl(int k);
    if (!reset)                                  return 4'b1100;
    if (ex_branch_taken || ex_jump)              return 4'b1111;
    if (owed_m[k] > 0 ||
        is_hazard(id_inst, ex_MemRead, ex_rt))   return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      owed_m[k] = 0;
      sc_m[k]   = 0;
      fc_m[k]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (ex_branch_taken || ex_jump) begin
        owed_m[k] = 0;
        if (fc_m[k] < max_m[k]) fc_m[k]++;
      end else if (owed_m[k] > 0) begin
        owed_m[k]--;
        if (sc_m[k] < max_m[k]) sc_m[k]++;
      end else if (is_hazard(id_inst, ex_MemRead, ex_rt)) begin
        owed_m[k] = lsc_m[k] - 1;
        if (sc_m[k] < max_m[k]) sc_m[k]++;
      end
    end
  endtask

  task automatic check_all(string tag);
    logic [3:0] exp_ctrl;
    for (int k = 0; k < NI; k++) begin
      exp_ctrl = model_ctrl(k);
      checks++;
      assert (ctrl_obs[k] === exp_ctrl) else begin
        failures++;
        $error("FAIL %s u%0d ctrl observed=%b expected=%b", tag, k, ctrl_obs[k], exp_ctrl);
      end
      checks++;
      assert (sc_obs[k] === 16'(sc_m[k])) else begin
        failures++;
        $error("FAIL %s u%0d stall_cycles observed=%0d expected=%0d", tag, k, sc_obs[k], sc_m[k]);
      end
      checks++;
      assert (fc_obs[k] === 16'(fc_m[k])) else begin
        failures++;
        $error("FAIL %s u%0d flush_count observed=%0d expected=%0d", tag, k, fc_obs[k], fc_m[k]);
      end
    end
    $display("step %-10s rst=%b mr=%b rt=%0d br=%b j=%b inst=%h u0=%b u1=%b u2=%b sc=%0d/%0d/%0d fc=%0d/%0d/%0d",
             tag, reset, ex_MemRead, ex_rt, ex_branch_taken, ex_jump, id_inst,
             ctrl_obs[0], ctrl_obs[1], ctrl_obs[2], sc0, sc1, sc2, fc0, fc1, fc2);
  endtask

  // Called just after a rising edge: inputs are already driven, let them
  // settle, check, then advance the model across the next edge.
  task automatic step(string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic drive(logic mr, logic [4:0] rt_ex, logic br, logic jmp, logic [31:0] inst);
    ex_MemRead      = mr;
    ex_rt           = rt_ex;
    ex_branch_taken = br;
    ex_jump         = jmp;
    id_inst         = inst;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_reset();
  endtask

  // add $9,$8,$10 ; lw $8,0($9) ; add $1,$0,$0
  localparam logic [31:0] I_ADD   = {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] I_LW    = {6'd35, 5'd9, 5'd8, 16'd0};
  localparam logic [31:0] I_ADD0  = {6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};
  localparam logic [31:0] I_SWRT  = {6'd43, 5'd3, 5'd8, 16'd4};

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] r_inst;
    logic [3:0]  sat_val;
    ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd8};

    // Reset held with a live hazard on the inputs: outputs stay normal.
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_ADD);
    assert_reset();
    @(posedge clk); #1;
    step("rst0");
    step("rst1");
    step("rst2");
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    step("idle");

    // Single load-use hazard; load leaves EX after one cycle.
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_ADD);
    step("lu_hit");
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    step("lu_s2");
    step("lu_s3");
    step("lu_resume");

    // No false hazards: $0 destination, and lw whose rt is a destination.
    drive(1'b1, 5'd0, 1'b0, 1'b0, I_ADD0);
    step("nofalse0");
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_LW);
    step("nofalse1");
    // sw reads rt, so it does hazard.
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_SWRT);
    step("sw_rt");
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    step("sw_s2");
    step("sw_s3");

    // Flush and hazard in the same cycle: flush wins.
    drive(1'b1, 5'd8, 1'b1, 1'b0, I_ADD);
    step("fl_prio");
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    step("fl_after");

    // Jump in the second cycle of a three-cycle stall aborts it.
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_ADD);
    step("ab_hit");
    drive(1'b0, 5'd0, 1'b0, 1'b1, I_ADD);
    step("ab_jump");
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    step("ab_run");

    // Reset in the middle of a stall abandons it immediately.
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_ADD);
    step("mr_hit");
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    assert_reset();
    step("mr_rst");
    reset = 1'b1;
    step("mr_run");

    // 20 back-to-back hazards: the 4-bit counter must stick at 15.
    drive(1'b1, 5'd8, 1'b0, 1'b0, I_ADD);
    for (int i = 0; i < 20; i++) step("sat");
    drive(1'b0, 5'd0, 1'b0, 1'b0, I_ADD);
    #2;
    sat_val = sc2;
    checks++;
    assert (sat_val === 4'hF) else begin
      failures++;
      $error("FAIL sat_hold u2 stall_cycles observed=%0d expected=15", sat_val);
    end
    @(posedge clk); #1;
    assert_reset();
    step("rst_again");
    reset = 1'b1;

    // Random traffic, biased towards register collisions.
    for (int n = 0; n < 400; n++) begin
      r_inst = $urandom;
      r_inst[31:26] = ops[$urandom_range(0, 5)];
      r_inst[25:21] = 5'($urandom_range(0, 7));
      r_inst[20:16] = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0), r_inst);
      if ($urandom_range(0, 49) == 0) assert_reset();
      else                           reset = 1'b1;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on simulated time so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
